// File: rtl/pzbcm_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pzbcm_arbiter_pkg
// Shared types and helpers for the pzbcm arbiter and its client agents.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package pzbcm_arbiter_pkg;

  // Widest grant vector the helper functions accept.
  localparam int MAX_GRANT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } pzbcm_arbiter_client_state;

  // One-hot grants need one bit per requester, binary grants an index.
  function automatic int calc_grant_width(input int requests, input int onehot);
    if (onehot != 0) begin
      return (requests < 1) ? 1 : requests;
    end
    return (requests <= 2) ? 1 : $clog2(requests);
  endfunction

  // True when the grant vector designates client id.
  function automatic logic is_granted(
    input logic [MAX_GRANT_WIDTH-1:0] grant,
    input int                         id,
    input bit                         onehot
  );
    logic [MAX_GRANT_WIDTH-1:0] shifted;
    shifted = grant >> id;
    if (onehot) begin
      return shifted[0];
    end
    return (grant == MAX_GRANT_WIDTH'(id));
  endfunction

endpackage

`default_nettype wire

// File: rtl/pzbcm_arbiter_client_timer.sv
// ---------------------------------------------------------------------------
// pzbcm_arbiter_client_timer
// Request wait counter with expiry compare. Saturates at TIMEOUT_CYCLES.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pzbcm_arbiter_client_timer #(
  parameter int TIMEOUT_CYCLES = 1024
)(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int                     COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] LIMIT       = COUNT_WIDTH'(TIMEOUT_CYCLES);

  logic [COUNT_WIDTH-1:0] count;

  // Count waiting cycles; held at zero outside the request phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_count_en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign o_expired = (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/pzbcm_arbiter_client.sv
// ---------------------------------------------------------------------------
// pzbcm_arbiter_client
// Requester-side agent: takes a burst command, requests the arbiter, streams
// the beats once granted and frees the grant on the final beat.
// Optional feature macro: PZBCM_ARBITER_CLIENT_TIMEOUT_EN (request timeout).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pzbcm_arbiter_client
  import pzbcm_arbiter_pkg::*;
#(
  parameter int CLIENT_ID      = 0,
  parameter int REQUESTS       = 2,
  parameter int ONEHOT_GRANT   = 1,
  parameter int GRANT_WIDTH    = calc_grant_width(REQUESTS, ONEHOT_GRANT),
  parameter int BURST_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 1024
)(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  output logic                   o_start_ready,
  input  logic [BURST_WIDTH-1:0] i_length,
  output logic                   o_request,
  input  logic [GRANT_WIDTH-1:0] i_grant,
  output logic                   o_free,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_last,
  output logic                   o_timeout
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  pzbcm_arbiter_client_state  state;
  logic [BURST_WIDTH-1:0]     length;
  logic [BURST_WIDTH-1:0]     count;
  logic                       timeout_pulse;
  logic [MAX_GRANT_WIDTH-1:0] grant_ext;
  logic                       granted;
  logic                       beat;
  logic                       expired;

  assign grant_ext = MAX_GRANT_WIDTH'(i_grant);

  // Request qualifies the grant so an idle binary grant of 0 or a stale
  // latched grant is never mistaken for ownership.
  assign granted = o_request && is_granted(grant_ext, CLIENT_ID, ONEHOT_GRANT != 0);

  assign o_start_ready = (state == IDLE);
  assign o_request     = (state == REQ) || (state == XFER);
  assign o_valid       = (state == XFER);
  assign o_last        = o_valid && (count == length);
  assign beat          = o_valid && i_ready;
  assign o_free        = beat && o_last;
  assign o_timeout     = timeout_pulse;

`ifdef PZBCM_ARBITER_CLIENT_TIMEOUT_EN
  pzbcm_arbiter_client_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (state != REQ),
    .i_count_en (!granted),
    .o_expired  (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Burst control FSM: IDLE -> REQ -> XFER -> IDLE, with optional abandon.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      length        <= '0;
      count         <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            length <= i_length;
            count  <= '0;
            state  <= REQ;
          end
        end
        REQ: begin
          // A grant in the expiry cycle takes precedence over the timeout.
          if (granted) begin
            state <= XFER;
          end else if (expired) begin
            state         <= IDLE;
            timeout_pulse <= 1'b1;
          end
        end
        XFER: begin
          if (beat) begin
            count <= count + 1'b1;
            if (o_last) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pzbcm_arbiter_client.sv
// ---------------------------------------------------------------------------
// tb_pzbcm_arbiter_client
// Directed self-checking bench for pzbcm_arbiter_client (one-hot and binary
// grant instances).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pzbcm_arbiter_client;

  logic       clk;
  logic       rst_n;

  logic       start, start_ready, request, free, valid, ready, last, timeout;
  logic [3:0] length;
  logic [1:0] grant;

  logic       bin_start, bin_start_ready, bin_request, bin_free, bin_valid;
  logic       bin_ready, bin_last, bin_timeout;
  logic [3:0] bin_length;
  logic [0:0] bin_grant;

  int n_checks = 0;
  int n_fail   = 0;

  pzbcm_arbiter_client #(
    .CLIENT_ID      (0),
    .REQUESTS       (2),
    .ONEHOT_GRANT   (1),
    .BURST_WIDTH    (4),
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .o_start_ready (start_ready),
    .i_length      (length),
    .o_request     (request),
    .i_grant       (grant),
    .o_free        (free),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_last        (last),
    .o_timeout     (timeout)
  );

  pzbcm_arbiter_client #(
    .CLIENT_ID      (0),
    .REQUESTS       (2),
    .ONEHOT_GRANT   (0),
    .BURST_WIDTH    (4),
    .TIMEOUT_CYCLES (8)
  ) u_bin (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (bin_start),
    .o_start_ready (bin_start_ready),
    .i_length      (bin_length),
    .o_request     (bin_request),
    .i_grant       (bin_grant),
    .o_free        (bin_free),
    .o_valid       (bin_valid),
    .i_ready       (bin_ready),
    .o_last        (bin_last),
    .o_timeout     (bin_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic val,
                         input logic lst, input logic fre);
    check_eq({tag, "_req"},  request, req);
    check_eq({tag, "_val"},  valid,   val);
    check_eq({tag, "_last"}, last,    lst);
    check_eq({tag, "_free"}, free,    fre);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  acc;
    bit  rp [5];
    logic exp_last;

    rst_n = 1'b0; start = 1'b0; length = '0; grant = '0; ready = 1'b1;
    bin_start = 1'b0; bin_length = '0; bin_grant = '0; bin_ready = 1'b1;

    // Reset values
    #3;
    chk_out("rst", 0, 0, 0, 0);
    check_eq("rst_rdy", start_ready, 1);
    check_eq("rst_tmo", timeout, 0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Test 1: length 3, immediate grant, ready always high
    start = 1'b1; length = 4'd3; #1;
    check_eq("t1_rdy", start_ready, 1);
    check_eq("t1_req_idle", request, 0);
    cyc();
    start = 1'b0; grant = 2'b01; #1;
    chk_out("t1_n1", 1, 0, 0, 0);
    check_eq("t1_rdy_busy", start_ready, 0);
    cyc();
    for (int b = 1; b <= 4; b++) begin
      ready = 1'b1; #1;
      chk_out($sformatf("t1_beat%0d", b), 1, 1, b == 4, b == 4);
      cyc();
    end
    grant = '0; #1;
    chk_out("t1_after", 0, 0, 0, 0);
    check_eq("t1_rdy_after", start_ready, 1);

    // Test 2: length 0, grant delayed 5 cycles; new command right after free
    start = 1'b1; length = 4'd0; #1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_out($sformatf("t2_wait%0d", i), 1, 0, 0, 0);
      check_eq("t2_tmo", timeout, 0);
      cyc();
    end
    grant = 2'b01; #1;
    chk_out("t2_grant", 1, 0, 0, 0);
    cyc();
    ready = 1'b1; #1;
    chk_out("t2_beat", 1, 1, 1, 1);
    cyc();
    grant = '0; #1;
    chk_out("t2_after", 0, 0, 0, 0);
    check_eq("t2_rdy_after", start_ready, 1);

    // Test 3: length 2 with ready pattern 1,0,0,1,1; grant on the other bit first
    start = 1'b1; length = 4'd2; grant = 2'b10; #1;
    cyc();
    start = 1'b0; #1;
    chk_out("t3_other", 1, 0, 0, 0);
    cyc();
    grant = 2'b01; #1;
    cyc();
    rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      ready = rp[k]; #1;
      exp_last = (acc == 2);
      chk_out($sformatf("t3_c%0d", k), 1, 1, exp_last, exp_last && rp[k]);
      if (rp[k]) acc++;
      cyc();
    end
    grant = '0; ready = 1'b1; #1;
    chk_out("t3_after", 0, 0, 0, 0);

    // Test 4: binary grant, grant code 0 while idle must not start anything
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t4_idle_req", bin_request, 0);
      check_eq("t4_idle_val", bin_valid, 0);
      cyc();
    end
    bin_start = 1'b1; bin_length = 4'd0; bin_grant = 1'b1; #1;
    cyc();
    bin_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t4_other_req", bin_request, 1);
      check_eq("t4_other_val", bin_valid, 0);
      cyc();
    end
    bin_grant = 1'b0; #1;
    cyc();
    #1;
    check_eq("t4_val", bin_valid, 1);
    check_eq("t4_last", bin_last, 1);
    check_eq("t4_free", bin_free, 1);
    cyc();
    #1;
    check_eq("t4_after_req", bin_request, 0);
    check_eq("t4_after_rdy", bin_start_ready, 1);

    // Test 5: request timeout behaviour
`ifdef PZBCM_ARBITER_CLIENT_TIMEOUT_EN
    // Wait count 0..8 across nine REQ cycles, abandon on the ninth
    start = 1'b1; length = 4'd1; grant = '0; #1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      #1;
      check_eq($sformatf("t5_req%0d", i), request, 1);
      check_eq($sformatf("t5_tmo%0d", i), timeout, 0);
      cyc();
    end
    #1;
    check_eq("t5_pulse", timeout, 1);
    check_eq("t5_drop", request, 0);
    check_eq("t5_rdy", start_ready, 1);
    cyc();
    #1;
    check_eq("t5_pulse_end", timeout, 0);
    // Grant arriving in the expiry cycle wins
    start = 1'b1; length = 4'd1; #1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      cyc();
    end
    grant = 2'b01; #1;
    cyc();
    #1;
    check_eq("t5_win_val", valid, 1);
    check_eq("t5_win_tmo", timeout, 0);
`else
    // Without the timeout feature REQ waits indefinitely
    start = 1'b1; length = 4'd1; grant = '0; #1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      check_eq($sformatf("t5_req%0d", i), request, 1);
      check_eq($sformatf("t5_tmo%0d", i), timeout, 0);
      cyc();
    end
    grant = 2'b01; #1;
    cyc();
`endif
    #1;
    chk_out("t5_beat1", 1, 1, 0, 0);
    cyc();
    #1;
    chk_out("t5_beat2", 1, 1, 1, 1);
    cyc();
    grant = '0; #1;
    chk_out("t5_after", 0, 0, 0, 0);

    // Test 6: asynchronous reset during beat 2 of 4
    start = 1'b1; length = 4'd3; #1;
    cyc();
    start = 1'b0; grant = 2'b01; #1;
    cyc();
    #1;
    chk_out("t6_beat1", 1, 1, 0, 0);
    cyc();
    #1;
    chk_out("t6_beat2", 1, 1, 0, 0);
    rst_n = 1'b0; #1;
    chk_out("t6_rst", 0, 0, 0, 0);
    check_eq("t6_rst_rdy", start_ready, 1);
    check_eq("t6_rst_tmo", timeout, 0);
    cyc(); cyc();
    rst_n = 1'b1; grant = '0; #1;
    cyc();
    #1;
    chk_out("t6_idle", 0, 0, 0, 0);
    check_eq("t6_idle_rdy", start_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pzbcm_arbiter_client.md
# pzbcm_arbiter_client

Requester-side agent for the pzbcm arbiter request/grant/free protocol. It accepts a burst command from local logic and raises its request line toward the shared arbiter. Once the arbiter grants it, the block streams the burst beats to the shared resource and asserts free on the final beat, which releases the arbiter's latched grant. One instance serves one arbiter request slot (CLIENT_ID).

## Interface
- CLIENT_ID, 0: index of this client's bit in the arbiter's request/free vectors and its grant code.
- REQUESTS, 2: number of arbiter requesters.
- ONEHOT_GRANT, 1: 1 means i_grant is one-hot; 0 means i_grant is a binary index.
- GRANT_WIDTH, calc_grant_width(REQUESTS, ONEHOT_GRANT): width of i_grant.
- BURST_WIDTH, 4: width of the length field.
- TIMEOUT_CYCLES, 1024: request wait limit. Used only when the timeout macro is defined.
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low. Shared with the arbiter.
- i_start  input  1  command valid.
- o_start_ready  output  1  command ready.
- i_length  input  BURST_WIDTH  beat count minus 1, so 1 to 2^BURST_WIDTH beats.
- o_request  output  1  to arbiter i_request[CLIENT_ID].
- i_grant  input  GRANT_WIDTH  from arbiter o_grant.
- o_free  output  1  to arbiter i_free[CLIENT_ID].
- o_valid  output  1  beat valid toward the shared resource.
- i_ready  input  1  beat accepted.
- o_last  output  1  final beat of the burst.
- o_timeout  output  1  one-cycle pulse when a request is abandoned. Constant 0 without the macro.

## Operation
- States: IDLE, REQ, XFER. Reset state is IDLE.
- IDLE
  - o_start_ready=1.
  - On i_start: latch i_length, clear the beat counter, go to REQ.
- REQ
  - o_request=1.
  - granted = o_request && (ONEHOT_GRANT ? i_grant[CLIENT_ID] : i_grant==CLIENT_ID).
  - The o_request qualifier is mandatory. A binary grant of 0, or a stale latched grant, must never be taken as ownership.
  - On granted: go to XFER.
- XFER
  - o_request=1 and o_valid=1.
  - o_last = (beat counter == latched length).
  - Beat handshake = o_valid && i_ready. On each handshake the counter increments.
  - On the last handshake: o_free=1 for that same cycle (combinational), then go to IDLE.
  - The grant is not re-checked in XFER; the arbiter holds it until free.
- o_request stays asserted continuously from REQ entry through the free cycle. It is 0 in IDLE.
- Counter width is BURST_WIDTH. No wrap occurs because the burst ends at the latched length.

## Timing
- Reset values: o_request=0, o_free=0, o_valid=0, o_last=0, o_timeout=0. o_start_ready=1, since it is decoded from the IDLE state.
- i_start accepted at edge N: o_request=1 from cycle N+1.
- Grant seen in cycle M: o_valid=1 from cycle M+1.
- Free asserted in cycle F: state is IDLE and o_request=0 in cycle F+1. A new command is accepted in F+1 at the earliest, giving a minimum of one idle cycle between bursts.
- Single-beat burst (i_length=0): o_last and o_free are valid in the first XFER cycle.
- i_ready low: o_valid, o_last and o_free hold. The free pulse appears only in the cycle of the last-beat handshake.
- Reset mid-operation: the block returns to IDLE immediately and the burst is dropped. The arbiter resets together with the block, so no free is needed.

## Configuration
- PZBCM_ARBITER_CLIENT_TIMEOUT_EN defined
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on REQ entry and increments each REQ cycle without a grant.
  - When the counter reaches TIMEOUT_CYCLES and the block is not granted in that cycle: drop o_request, pulse o_timeout for 1 cycle, go to IDLE.
  - A grant in the same cycle as expiry wins: the block goes to XFER and there is no timeout.
- Not defined: no counter, o_timeout tied to 0, and REQ waits indefinitely.

## Structure
- pzbcm_arbiter_pkg receives:
  - the state enum pzbcm_arbiter_client_state (IDLE/REQ/XFER);
  - a function is_granted(grant, id, onehot).
- calc_grant_width is reused from the same package.
- Sub-module pzbcm_arbiter_client_timer: wait counter plus expiry compare. It is instantiated only under the macro.

## Test plan
- Length 3 with immediate grant, i_ready always 1 -> o_request from N+1, 4 valid beats, o_last and o_free on beat 4, o_request=0 on the next cycle.
- Length 0 with grant delayed 5 cycles -> o_request held 5 cycles, a single beat carries both o_last and o_free, then back to IDLE.
- Length 2 with i_ready toggling 1,0,0,1,1 -> o_free only on the final accepted beat, and outputs stable while i_ready=0.
- Binary grant (ONEHOT_GRANT=0), CLIENT_ID=0, i_grant=0 while idle -> no transfer starts.
- Macro defined, TIMEOUT_CYCLES=8, no grant -> o_timeout pulses once after 8 REQ cycles, o_request drops, and o_start_ready=1 on the next cycle. Grant in the expiry cycle -> XFER with no timeout.
- i_rst_n asserted mid-burst (beat 2 of 4) -> all outputs return to reset values asynchronously, and the block is in IDLE after release.
